cv32e40p_lsu_wb_stage: RTL and testbench

- Write-back-side companion to the execute stage. Sits directly downstream of the EX/WB pipeline register.
- Tracks outstanding data-bus transactions issued from EX and consumes the data-bus response.
- Aligns and sign/zero-extends load data, then drives the LSU register-file write port.
- Produces wb_ready_o, which EX uses as its wb_ready input for back-pressure.

---
 rtl/cv32e40p_lsu_wb_stage.sv | 135 +++++++++++++
 tb/tb_cv32e40p_lsu_wb_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_lsu_wb_stage.sv
// LSU write-back stage: tracks outstanding data-bus transactions, consumes the
// bus response, aligns/extends load data and drives the LSU register-file port.
module cv32e40p_lsu_wb_stage #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic              req_we_i,
    input  logic [1:0]        req_type_i,
    input  logic              req_sign_ext_i,
    input  logic [1:0]        req_addr_lo_i,
    input  logic [ADDR_W-1:0] req_waddr_i,
    output logic              wb_ready_o,
    input  logic              data_rvalid_i,
    input  logic [31:0]       data_rdata_i,
    input  logic              data_err_i,
    output logic              regfile_we_o,
    output logic [ADDR_W-1:0] regfile_waddr_o,
    output logic [31:0]       regfile_wdata_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] err_waddr_o,
    output logic              busy_o,
    output logic              protocol_err_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    // Handshake: a request is accepted when req_valid_i & wb_ready_o; a request
    // presented while wb_ready_o is low is dropped without any state change.
    // Every data_rvalid_i with an entry outstanding retires the head entry.

    logic              mem_we   [DEPTH];
    logic [1:0]        mem_type [DEPTH];
    logic              mem_sx   [DEPTH];
    logic [1:0]        mem_off  [DEPTH];
    logic [ADDR_W-1:0] mem_waddr[DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic push;
    logic pop;

    logic              head_we;
    logic [1:0]        head_type;
    logic              head_sx;
    logic [1:0]        head_off;
    logic [ADDR_W-1:0] head_waddr;
    logic [31:0]       shifted;
    logic [31:0]       result;

    // A full FIFO can still accept when the head retires in the same cycle.
    assign wb_ready_o = (count < FULL) | ((count == FULL) & data_rvalid_i);
    assign busy_o     = (count != '0);
    assign push       = req_valid_i & wb_ready_o;
    assign pop        = data_rvalid_i & (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_we[wr_ptr]    <= req_we_i;
            mem_type[wr_ptr]  <= req_type_i;
            mem_sx[wr_ptr]    <= req_sign_ext_i;
            mem_off[wr_ptr]   <= req_addr_lo_i;
            mem_waddr[wr_ptr] <= req_waddr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_we    = mem_we[rd_ptr];
    assign head_type  = mem_type[rd_ptr];
    assign head_sx    = mem_sx[rd_ptr];
    assign head_off   = mem_off[rd_ptr];
    assign head_waddr = mem_waddr[rd_ptr];

    // Right-shift by the byte offset; bytes above the word come in as zero.
    always_comb begin
        shifted = data_rdata_i >> {head_off, 3'b000};
        result  = shifted;
        case (head_type)
            2'b00:   result = {{24{head_sx & shifted[7]}}, shifted[7:0]};
            2'b01:   result = {{16{head_sx & shifted[15]}}, shifted[15:0]};
            default: result = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regfile_we_o    <= 1'b0;
            regfile_waddr_o <= '0;
            regfile_wdata_o <= '0;
            err_o           <= 1'b0;
            err_waddr_o     <= '0;
            protocol_err_o  <= 1'b0;
        end else begin
            regfile_we_o <= pop & ~head_we & ~data_err_i;
            if (pop & ~head_we & ~data_err_i) begin
                regfile_waddr_o <= head_waddr;
                regfile_wdata_o <= result;
            end
            err_o <= pop & data_err_i;
            if (pop & data_err_i) begin
                err_waddr_o <= head_waddr;
            end
            if (data_rvalid_i & (count == '0)) begin
                protocol_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cv32e40p_lsu_wb_stage.sv
// Randomized + directed scoreboard bench for cv32e40p_lsu_wb_stage.
module tb_cv32e40p_lsu_wb_stage;

  localparam int DEPTH  = 2;
  localparam int ADDR_W = 6;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_we;
  logic [1:0]        req_type;
  logic              req_sign_ext;
  logic [1:0]        req_addr_lo;
  logic [ADDR_W-1:0] req_waddr;
  logic              wb_ready_o;
  logic              data_rvalid;
  logic [31:0]       data_rdata;
  logic              data_err;
  logic              regfile_we_o;
  logic [ADDR_W-1:0] regfile_waddr_o;
  logic [31:0]       regfile_wdata_o;
  logic              err_o;
  logic [ADDR_W-1:0] err_waddr_o;
  logic              busy_o;
  logic              protocol_err_o;

  cv32e40p_lsu_wb_stage #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_we_i(req_we), .req_type_i(req_type),
    .req_sign_ext_i(req_sign_ext), .req_addr_lo_i(req_addr_lo), .req_waddr_i(req_waddr),
    .wb_ready_o(wb_ready_o),
    .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata), .data_err_i(data_err),
    .regfile_we_o(regfile_we_o), .regfile_waddr_o(regfile_waddr_o),
    .regfile_wdata_o(regfile_wdata_o),
    .err_o(err_o), .err_waddr_o(err_waddr_o),
    .busy_o(busy_o), .protocol_err_o(protocol_err_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model state
  typedef struct packed {
    logic              we;
    logic [1:0]        typ;
    logic              sx;
    logic [1:0]        off;
    logic [ADDR_W-1:0] waddr;
  } meta_t;

  meta_t                      mq[$];
  logic [ADDR_W+31:0]         exp_q[$];
  logic [ADDR_W-1:0]          exp_err_q[$];
  logic                       exp_perr;
  int                         checks;
  int                         failures;

  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] t,
                                           input logic sx, input logic [1:0] off);
    logic [31:0] s;
    s = d >> (8 * off);
    if (t == 2'd0) begin
      s = s % 256;
      if (sx && s >= 128) s = s + 32'hFFFF_FF00;
    end else if (t == 2'd1) begin
      s = s % 65536;
      if (sx && s >= 32768) s = s + 32'hFFFF_0000;
    end
    return s;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // driver: one clock cycle of stimulus, model updated at the clock edge
  task automatic cycle(input logic rv, input logic we, input logic [1:0] typ,
                       input logic sx, input logic [1:0] off, input logic [ADDR_W-1:0] wa,
                       input logic rsp, input logic [31:0] rd, input logic er);
    logic  exp_ready;
    logic  do_pop;
    meta_t head;
    req_valid    = rv;
    req_we       = we;
    req_type     = typ;
    req_sign_ext = sx;
    req_addr_lo  = off;
    req_waddr    = wa;
    data_rvalid  = rsp;
    data_rdata   = rd;
    data_err     = er;
    #1;
    exp_ready = (mq.size() < DEPTH) || (mq.size() == DEPTH && rsp);
    chk("wb_ready", {63'd0, wb_ready_o}, {63'd0, exp_ready});
    chk("busy", {63'd0, busy_o}, {63'd0, mq.size() != 0});
    do_pop = rsp && (mq.size() != 0);
    head   = '0;
    if (do_pop) head = mq[0];
    @(posedge clk);
    if (do_pop) begin
      void'(mq.pop_front());
      if (er) exp_err_q.push_back(head.waddr);
      else if (!head.we) exp_q.push_back({head.waddr, ref_load(rd, head.typ, head.sx, head.off)});
    end else if (rsp) begin
      exp_perr = 1'b1;
    end
    if (rv && exp_ready) mq.push_back('{we: we, typ: typ, sx: sx, off: off, waddr: wa});
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 2'd0, 0, 2'd0, '0, 0, 32'd0, 0);
  endtask

  task automatic load(input logic [1:0] typ, input logic sx, input logic [1:0] off,
                      input logic [ADDR_W-1:0] wa);
    cycle(1, 0, typ, sx, off, wa, 0, 32'd0, 0);
  endtask

  task automatic resp(input logic [31:0] rd, input logic er);
    cycle(0, 0, 2'd0, 0, 2'd0, '0, 1, rd, er);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 0; req_we = 0; req_type = 0; req_sign_ext = 0;
    req_addr_lo = 0; req_waddr = '0; data_rvalid = 0; data_rdata = '0; data_err = 0;
    @(posedge clk);
    mq.delete();
    exp_q.delete();
    exp_err_q.delete();
    exp_perr = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("rst_regfile_we", {63'd0, regfile_we_o}, 64'd0);
    chk("rst_regfile_waddr", {58'd0, regfile_waddr_o}, 64'd0);
    chk("rst_regfile_wdata", {32'd0, regfile_wdata_o}, 64'd0);
    chk("rst_err", {63'd0, err_o}, 64'd0);
    chk("rst_err_waddr", {58'd0, err_waddr_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_protocol_err", {63'd0, protocol_err_o}, 64'd0);
    chk("rst_wb_ready", {63'd0, wb_ready_o}, 64'd1);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [ADDR_W+31:0] e;
    logic [ADDR_W-1:0]  ew;
    if (!rst) begin
      if (regfile_we_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=waddr %0h data %0h required=no write",
                   regfile_waddr_o, regfile_wdata_o);
        end else begin
          e = exp_q.pop_front();
          chk("wr_waddr", {58'd0, regfile_waddr_o}, {58'd0, e[ADDR_W+31:32]});
          chk("wr_wdata", {32'd0, regfile_wdata_o}, {32'd0, e[31:0]});
        end
      end
      if (err_o) begin
        if (exp_err_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_err actual=err_o 1 required=err_o 0");
        end else begin
          ew = exp_err_q.pop_front();
          chk("err_waddr", {58'd0, err_waddr_o}, {58'd0, ew});
        end
      end
      chk("protocol_err", {63'd0, protocol_err_o}, {63'd0, exp_perr});
    end
  end

  // stimulus
  initial begin
    checks   = 0;
    failures = 0;
    exp_perr = 1'b0;
    rst      = 1'b1;
    do_reset();

    load(2'd0, 1, 2'd2, 6'd5);
    resp(32'h1280_3456, 0);
    idle();
    load(2'd1, 0, 2'd0, 6'd7);
    resp(32'hABCD_8001, 0);
    load(2'd2, 0, 2'd0, 6'd3);
    resp(32'hDEAD_BEEF, 0);
    idle();

    load(2'd2, 0, 2'd0, 6'd1);
    load(2'd2, 0, 2'd0, 6'd2);
    load(2'd2, 0, 2'd0, 6'd10);
    cycle(1, 0, 2'd2, 0, 2'd0, 6'd3, 1, $urandom, 0);
    resp($urandom, 0);
    resp($urandom, 0);
    idle();

    cycle(1, 1, 2'd2, 0, 2'd0, 6'd0, 0, 32'd0, 0);
    load(2'd2, 0, 2'd0, 6'd9);
    resp($urandom, 0);
    resp($urandom, 0);
    idle();

    load(2'd2, 0, 2'd0, 6'd4);
    resp($urandom, 1);
    idle();
    idle();

    resp($urandom, 0);
    idle();
    idle();

    load(2'd0, 1, 2'd1, 6'd12);
    do_reset();
    resp(32'hFFFF_FFFF, 0);
    idle();
    idle();

    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) < 60), ($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            ADDR_W'($urandom_range(0, 63)), ($urandom_range(0, 99) < 55), $urandom,
            ($urandom_range(0, 7) == 0));
    end
    for (int i = 0; i < 4; i++) resp($urandom, 0);
    idle();
    idle();
    chk("write_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("err_queue_drained", 64'(exp_err_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
